rgb_pwm_fader: RTL and testbench

//   Parametrised N-channel PWM engine with per-channel static, fade and breathe modes.

---
 rtl/rgb_pwm_fader.sv | 186 ++++++++++++++++++
 tb/tb_rgb_pwm_fader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: N-channel PWM engine with static, fade and breathe modes.
// Ports: clk/rst_n, cfg_* write handshake, pwm_out/busy per channel, period_start pulse.
module rgb_pwm_fader #(
  parameter  int NCH    = 3,
  parameter  int PWM_W  = 8,
  parameter  int RATE_W = 16,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [PWM_W-1:0]  cfg_duty,
  input  logic [RATE_W-1:0] cfg_rate,
  output logic [NCH-1:0]    pwm_out,
  output logic [NCH-1:0]    busy,
  output logic              period_start
);

  typedef enum logic [1:0] {
    M_STATIC  = 2'b00,
    M_FADE    = 2'b01,
    M_BREATHE = 2'b10
  } mode_e;

  localparam logic [PWM_W-1:0] PCNT_MAX = '1;

  logic [PWM_W-1:0]  pcnt_q, pcnt_d;
  logic              ps_q, ps_d;
  logic              ready_q, ready_d;
  logic [NCH-1:0]    pwm_q, pwm_d;
  logic [NCH-1:0]    busy_q, busy_d;

  logic [PWM_W-1:0]  act_q   [NCH];
  logic [PWM_W-1:0]  act_d   [NCH];
  logic [PWM_W-1:0]  cur_q   [NCH];
  logic [PWM_W-1:0]  cur_d   [NCH];
  logic [PWM_W-1:0]  tgt_q   [NCH];
  logic [PWM_W-1:0]  tgt_d   [NCH];
  logic [RATE_W-1:0] rate_q  [NCH];
  logic [RATE_W-1:0] rate_d  [NCH];
  logic [RATE_W-1:0] presc_q [NCH];
  logic [RATE_W-1:0] presc_d [NCH];
  mode_e             mode_q  [NCH];
  mode_e             mode_d  [NCH];
  logic [NCH-1:0]    up_q, up_d;

  logic cfg_acc;

  assign cfg_acc      = cfg_valid & ready_q;
  assign cfg_ready    = ready_q;
  assign pwm_out      = pwm_q;
  assign busy         = busy_q;
  assign period_start = ps_q;

  // Counter, period pulse and output compare.
  // duty_act only reloads on the last count so a
  // running period is never cut short or stretched.
  always_comb begin
    pcnt_d  = pcnt_q + 1'b1;
    ps_d    = (pcnt_q == '0);
    ready_d = 1'b1;
    pwm_d   = '0;
    for (int c = 0; c < NCH; c++) begin
      pwm_d[c] = (pcnt_q < act_q[c]);
      act_d[c] = (pcnt_q == PCNT_MAX) ? cur_q[c]
                                      : act_q[c];
    end
  end

  // Per-channel ramp engine.
  always_comb begin
    logic [RATE_W-1:0] rate_eff;
    logic              tick;
    logic              wr;
    up_d   = up_q;
    busy_d = '0;
    for (int c = 0; c < NCH; c++) begin
      mode_d[c]  = mode_q[c];
      tgt_d[c]   = tgt_q[c];
      rate_d[c]  = rate_q[c];
      cur_d[c]   = cur_q[c];

      rate_eff = (rate_q[c] == '0) ? RATE_W'(1)
                                   : rate_q[c];
      tick = (presc_q[c] == rate_eff - RATE_W'(1));
      presc_d[c] = tick ? '0 : presc_q[c] + 1'b1;

      if (tick) begin
        unique case (1'b1)
          (mode_q[c] == M_FADE): begin
            if (cur_q[c] < tgt_q[c])
              cur_d[c] = cur_q[c] + 1'b1;
            else if (cur_q[c] > tgt_q[c])
              cur_d[c] = cur_q[c] - 1'b1;
          end
          (mode_q[c] == M_BREATHE): begin
            // At the peak (or above it) turn round
            // and step down in the same tick; at 0
            // turn round and step up. Peak 0 holds.
            if (up_q[c]) begin
              if (cur_q[c] < tgt_q[c]) begin
                cur_d[c] = cur_q[c] + 1'b1;
              end else begin
                up_d[c] = 1'b0;
                if (cur_q[c] != '0)
                  cur_d[c] = cur_q[c] - 1'b1;
              end
            end else begin
              if (cur_q[c] != '0) begin
                cur_d[c] = cur_q[c] - 1'b1;
              end else begin
                up_d[c] = 1'b1;
                if (tgt_q[c] != '0)
                  cur_d[c] = PWM_W'(1);
              end
            end
          end
          default: ;
        endcase
      end

      // A write replaces whatever the tick did.
      wr = cfg_acc && (int'(cfg_ch) == c);
      if (wr) begin
        tgt_d[c]   = cfg_duty;
        rate_d[c]  = cfg_rate;
        presc_d[c] = '0;
        cur_d[c]   = cur_q[c];
        up_d[c]    = up_q[c];
        unique case (cfg_mode)
          2'b01: mode_d[c] = M_FADE;
          2'b10: begin
            mode_d[c] = M_BREATHE;
            up_d[c]   = 1'b1;
          end
          default: begin
            mode_d[c] = M_STATIC;
            cur_d[c]  = cfg_duty;
          end
        endcase
      end

      busy_d[c] = ((mode_d[c] == M_FADE) &&
                   (cur_d[c] != tgt_d[c])) ||
                  (mode_d[c] == M_BREATHE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q  <= '0;
      ps_q    <= 1'b0;
      ready_q <= 1'b0;
      pwm_q   <= '0;
      busy_q  <= '0;
      up_q    <= '0;
      for (int c = 0; c < NCH; c++) begin
        act_q[c]   <= '0;
        cur_q[c]   <= '0;
        tgt_q[c]   <= '0;
        rate_q[c]  <= '0;
        presc_q[c] <= '0;
        mode_q[c]  <= M_STATIC;
      end
    end else begin
      pcnt_q  <= pcnt_d;
      ps_q    <= ps_d;
      ready_q <= ready_d;
      pwm_q   <= pwm_d;
      busy_q  <= busy_d;
      up_q    <= up_d;
      for (int c = 0; c < NCH; c++) begin
        act_q[c]   <= act_d[c];
        cur_q[c]   <= cur_d[c];
        tgt_q[c]   <= tgt_d[c];
        rate_q[c]  <= rate_d[c];
        presc_q[c] <= presc_d[c];
        mode_q[c]  <= mode_d[c];
      end
    end
  end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// tb_rgb_pwm_fader: scoreboard bench for rgb_pwm_fader.
// A brightness model predicts every output cycle; a monitor compares.
module tb_rgb_pwm_fader;

  localparam int NCH = 3;
  localparam int PER = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = '0;
  logic [1:0]  cfg_mode = '0;
  logic [7:0]  cfg_duty = '0;
  logic [15:0] cfg_rate = '0;
  logic [2:0]  pwm_out;
  logic [2:0]  busy;
  logic        period_start;

  int n_tests = 0;
  int n_fail  = 0;

  rgb_pwm_fader #(.NCH(3), .PWM_W(8), .RATE_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_duty(cfg_duty), .cfg_rate(cfg_rate),
    .pwm_out(pwm_out), .busy(busy),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] pwm;
    logic [2:0] busy;
    logic       ps;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model: brightness level per channel,
  // the level actually shown in the running period,
  // and clocks elapsed since the last step.
  int m_pos;
  int m_shown [NCH];
  int m_lvl   [NCH];
  int m_goal  [NCH];
  int m_kind  [NCH];
  int m_every [NCH];
  int m_wait  [NCH];
  bit m_rise  [NCH];
  bit m_rdy;

  always @(posedge clk) begin
    exp_t e;
    bit wr;
    e.pwm = '0; e.busy = '0; e.ps = 1'b0; e.rdy = 1'b0;
    if (!rst_n) begin
      m_pos = 0;
      m_rdy = 0;
      for (int c = 0; c < NCH; c++) begin
        m_shown[c] = 0; m_lvl[c] = 0; m_goal[c] = 0;
        m_kind[c] = 0; m_every[c] = 0; m_wait[c] = 0;
        m_rise[c] = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++)
        e.pwm[c] = (m_pos < m_shown[c]);
      e.ps = (m_pos == 0);
      if (m_pos == PER - 1)
        for (int c = 0; c < NCH; c++) m_shown[c] = m_lvl[c];
      m_pos = (m_pos + 1) % PER;
      wr = cfg_valid && m_rdy;
      for (int c = 0; c < NCH; c++) begin
        if (wr && int'(cfg_ch) == c) begin
          m_goal[c]  = cfg_duty;
          m_every[c] = (cfg_rate == 0) ? 1 : int'(cfg_rate);
          m_wait[c]  = 0;
          m_kind[c]  = (cfg_mode == 2'd1) ? 1 :
                       (cfg_mode == 2'd2) ? 2 : 0;
          if (m_kind[c] == 0) m_lvl[c] = cfg_duty;
          if (m_kind[c] == 2) m_rise[c] = 1;
        end else begin
          m_wait[c]++;
          if (m_wait[c] >= m_every[c]) begin
            m_wait[c] = 0;
            if (m_kind[c] == 1) begin
              if (m_lvl[c] < m_goal[c]) m_lvl[c]++;
              else if (m_lvl[c] > m_goal[c]) m_lvl[c]--;
            end else if (m_kind[c] == 2) begin
              if (m_rise[c] && m_lvl[c] < m_goal[c]) begin
                m_lvl[c]++;
              end else if (m_rise[c]) begin
                m_rise[c] = 0;
                if (m_lvl[c] > 0) m_lvl[c]--;
              end else if (m_lvl[c] > 0) begin
                m_lvl[c]--;
              end else begin
                m_rise[c] = 1;
                if (m_goal[c] > 0) m_lvl[c] = 1;
              end
            end
          end
        end
        e.busy[c] = (m_kind[c] == 1 && m_lvl[c] != m_goal[c])
                    || m_kind[c] == 2;
      end
      m_rdy = 1;
      e.rdy = 1'b1;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (pwm_out !== e.pwm || busy !== e.busy ||
          period_start !== e.ps || cfg_ready !== e.rdy) begin
        n_fail++;
        $display("FAIL cycle t=%0t got pwm=%b busy=%b ps=%b rdy=%b required pwm=%b busy=%b ps=%b rdy=%b",
                 $time, pwm_out, busy, period_start, cfg_ready,
                 e.pwm, e.busy, e.ps, e.rdy);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d required %0d", name, got, want);
    end
  endtask

  task automatic wr_cfg(input int ch, input int mode,
                        input int duty, input int rate);
    bit ok;
    int n;
    @(posedge clk);
    #2;
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_mode  = 2'(mode);
    cfg_duty  = 8'(duty);
    cfg_rate  = 16'(rate);
    n = 0;
    do begin
      ok = cfg_ready;
      @(posedge clk);
      n++;
    end while (!ok && n < 10);
    #2;
    cfg_valid = 1'b0;
    if (!ok) chk("cfg_accept_timeout", 0, 1);
  endtask

  // Count high clocks of pwm_out[ch] over one whole period.
  task automatic count_high(input int ch, output int cnt);
    int n;
    cnt = 0;
    n = 0;
    @(negedge clk);
    while (!period_start && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) chk("period_start_timeout", 0, 1);
    for (int i = 0; i < PER; i++) begin
      if (pwm_out[ch]) cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt;
    int n;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_first_cycle", cfg_ready, 0);
    @(negedge clk);
    chk("ready_second_cycle", cfg_ready, 1);

    wr_cfg(0, 0, 64, 0);
    repeat (300) @(posedge clk);
    count_high(0, cnt);
    chk("static_duty64", cnt, 64);
    wr_cfg(0, 0, 0, 0);
    repeat (300) @(posedge clk);
    count_high(0, cnt);
    chk("static_duty0", cnt, 0);
    wr_cfg(0, 3, 255, 0);
    repeat (300) @(posedge clk);
    count_high(0, cnt);
    chk("static_duty255", cnt, 255);

    wr_cfg(1, 1, 200, 4);
    n = 0;
    @(negedge clk);
    while (busy[1] && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("fade_busy_clocks", n, 800);
    wr_cfg(1, 0, 0, 0);
    wr_cfg(1, 1, 200, 4);
    repeat (400) @(posedge clk);
    wr_cfg(1, 1, 50, 4);
    repeat (500) @(posedge clk);

    wr_cfg(2, 2, 10, 1);
    repeat (200) @(negedge clk);
    chk("breathe_busy", busy[2], 1);

    n = 0;
    @(negedge clk);
    while (!period_start && n < 600) begin
      @(negedge clk);
      n++;
    end
    repeat (98) @(posedge clk);
    wr_cfg(0, 0, 30, 0);
    repeat (600) @(posedge clk);

    wr_cfg(3, 1, 77, 0);
    wr_cfg(1, 1, 0, 0);
    repeat (300) @(posedge clk);
    wr_cfg(2, 2, 5, 3);
    repeat (3) wr_cfg(2, 2, 6, 2);

    repeat (300) begin
      repeat ($urandom_range(0, 20)) @(posedge clk);
      wr_cfg($urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                         : $urandom_range(0, 24),
             $urandom_range(0, 6));
    end
    repeat (600) @(posedge clk);

    wr_cfg(2, 2, 200, 2);
    wr_cfg(1, 1, 150, 1);
    repeat (50) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pwm", pwm_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", cfg_ready, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("release_ready_c1", cfg_ready, 0);
    @(negedge clk);
    chk("release_ready_c2", cfg_ready, 1);
    chk("release_busy", busy, 0);
    repeat (300) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
